slot_controller: RTL and testbench

Sequencer for the three-reel slot game. It takes the start and stop buttons plus a slow tick enable and drives per-reel step enables for three `slot` LFSR reels clocked on the same `clk`. It stops the reels one at a time with a fixed stagger and scores the frozen reel values. It also keeps a saturating credit balance, and sits between the button debouncers/clock divider and the reel and display logic.

---
 rtl/slot_controller.sv | 200 ++++++++++++++++++++
 tb/tb_slot_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : slot_controller
// Purpose  : Sequencer for a three-reel slot game. Spins all reels on a start
//            press, stops them one at a time with a fixed tick stagger, scores
//            the frozen reel values and keeps a saturating credit balance.
// Ports    : clk          - system clock
//            rst          - asynchronous active-low reset
//            tick         - one-clk slow tick enable, drives all tick counters
//            start_btn    - debounced start level, acted on at rising edge
//            stop_btn     - debounced stop level, acted on at rising edge
//            reel0..reel2 - current 4-bit reel values
//            reel_step    - per-reel step enable (run flag AND live tick)
//            credits      - current credit balance
//            win_triple   - last spin was three-of-a-kind
//            win_pair     - last spin had exactly two matching reels
//            busy         - high in every state except IDLE
//            state        - current state code
// Revision : 1.0 - initial release
// ============================================================================
module slot_controller #(
  parameter int STAGGER_TICKS  = 4,
  parameter int MAX_SPIN_TICKS = 64,
  parameter int HOLD_TICKS     = 8,
  parameter int CREDIT_W       = 8,
  parameter int START_CREDITS  = 10,
  parameter int PAYOUT_TRIPLE  = 10,
  parameter int PAYOUT_PAIR    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start_btn,
  input  logic                stop_btn,
  input  logic [3:0]          reel0,
  input  logic [3:0]          reel1,
  input  logic [3:0]          reel2,
  output logic [2:0]          reel_step,
  output logic [CREDIT_W-1:0] credits,
  output logic                win_triple,
  output logic                win_pair,
  output logic                busy,
  output logic [2:0]          state
);

  // One shared tick counter, sized for the longest phase.
  localparam int c_MAX_A   = (STAGGER_TICKS > MAX_SPIN_TICKS) ? STAGGER_TICKS : MAX_SPIN_TICKS;
  localparam int c_CNT_MAX = (c_MAX_A > HOLD_TICKS) ? c_MAX_A : HOLD_TICKS;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0]  c_SPIN_LAST  = c_CNT_W'(MAX_SPIN_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  c_STAG_LAST  = c_CNT_W'(STAGGER_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  c_HOLD_LAST  = c_CNT_W'(HOLD_TICKS - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [CREDIT_W-1:0] c_START      = CREDIT_W'(START_CREDITS);
  localparam logic [CREDIT_W:0]   c_PAY_TRIPLE = (CREDIT_W + 1)'(PAYOUT_TRIPLE);
  localparam logic [CREDIT_W:0]   c_PAY_PAIR   = (CREDIT_W + 1)'(PAYOUT_PAIR);
  localparam logic [CREDIT_W:0]   c_CREDIT_SAT = {1'b0, {CREDIT_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    STOP1 = 3'd2,
    STOP2 = 3'd3,
    EVAL  = 3'd4,
    SHOW  = 3'd5
  } state_t;

  state_t              r_state;
  logic [2:0]          r_run;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [CREDIT_W-1:0] r_credits;
  logic                r_win_triple;
  logic                r_win_pair;
  logic                r_start_q;
  logic                r_stop_q;

  state_t              w_state_nxt;
  logic [2:0]          w_run_nxt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [CREDIT_W-1:0] w_credits_nxt;
  logic                w_win_triple_nxt;
  logic                w_win_pair_nxt;
  logic                w_start_edge;
  logic                w_stop_edge;
  logic [CREDIT_W:0]   w_sum;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_run        <= 3'b000;
      r_cnt        <= '0;
      r_credits    <= c_START;
      r_win_triple <= 1'b0;
      r_win_pair   <= 1'b0;
      r_start_q    <= 1'b0;
      r_stop_q     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= w_run_nxt;
      r_cnt        <= w_cnt_nxt;
      r_credits    <= w_credits_nxt;
      r_win_triple <= w_win_triple_nxt;
      r_win_pair   <= w_win_pair_nxt;
      r_start_q    <= start_btn;
      r_stop_q     <= stop_btn;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt      = r_state;
    w_run_nxt        = r_run;
    w_cnt_nxt        = r_cnt;
    w_credits_nxt    = r_credits;
    w_win_triple_nxt = r_win_triple;
    w_win_pair_nxt   = r_win_pair;
    w_start_edge     = start_btn & ~r_start_q;
    w_stop_edge      = stop_btn & ~r_stop_q;
    w_sum            = {1'b0, r_credits};

    case (r_state)
      IDLE: begin
        if (w_start_edge && (r_credits != '0)) begin
          w_state_nxt      = SPIN;
          w_credits_nxt    = r_credits - 1'b1;
          w_run_nxt        = 3'b111;
          w_cnt_nxt        = '0;
          w_win_triple_nxt = 1'b0;
          w_win_pair_nxt   = 1'b0;
        end
      end
      SPIN: begin
        // A stop press and the timeout on the same cycle collapse into one stop.
        if (w_stop_edge || (tick && (r_cnt == c_SPIN_LAST))) begin
          w_state_nxt  = STOP1;
          w_run_nxt[0] = 1'b0;
          w_cnt_nxt    = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      STOP1: begin
        if (tick && (r_cnt == c_STAG_LAST)) begin
          w_state_nxt  = STOP2;
          w_run_nxt[1] = 1'b0;
          w_cnt_nxt    = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      STOP2: begin
        if (tick && (r_cnt == c_STAG_LAST)) begin
          w_state_nxt  = EVAL;
          w_run_nxt[2] = 1'b0;
          w_cnt_nxt    = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      EVAL: begin
        // Reels have been frozen since the previous cycle.
        if ((reel0 == reel1) && (reel1 == reel2)) begin
          w_win_triple_nxt = 1'b1;
          w_sum            = {1'b0, r_credits} + c_PAY_TRIPLE;
        end else if ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2)) begin
          w_win_pair_nxt = 1'b1;
          w_sum          = {1'b0, r_credits} + c_PAY_PAIR;
        end
        // Extra carry bit lets the overflow be detected and clamped.
        w_credits_nxt = (w_sum > c_CREDIT_SAT) ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];
        w_state_nxt   = SHOW;
        w_cnt_nxt     = '0;
      end
      SHOW: begin
        if (tick && (r_cnt == c_HOLD_LAST)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (tick) begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_run_nxt   = 3'b000;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign reel_step  = r_run & {3{tick}};
  assign credits    = r_credits;
  assign win_triple = r_win_triple;
  assign win_pair   = r_win_pair;
  assign busy       = (r_state != IDLE);
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_controller
// Purpose  : Randomized self-checking bench for slot_controller. Each spin is
//            planned as a timeline: the tick pattern is drawn up front, then the
//            cycle of every phase boundary is found by counting ticks, and the
//            state, step enables, credits and flags are checked every cycle
//            against that timeline and a payout model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_controller;

  localparam int STAG     = 4;
  localparam int MAXSPIN  = 64;
  localparam int HOLD     = 8;
  localparam int CW       = 8;
  localparam int START_C  = 10;
  localparam int P_TRIPLE = 10;
  localparam int P_PAIR   = 2;
  localparam int SAT      = (1 << CW) - 1;
  localparam int NCYC     = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          start_btn;
  logic          stop_btn;
  logic [3:0]    reel0, reel1, reel2;
  logic [2:0]    reel_step;
  logic [CW-1:0] credits;
  logic          win_triple, win_pair, busy;
  logic [2:0]    state;

  slot_controller #(
    .STAGGER_TICKS(STAG), .MAX_SPIN_TICKS(MAXSPIN), .HOLD_TICKS(HOLD),
    .CREDIT_W(CW), .START_CREDITS(START_C), .PAYOUT_TRIPLE(P_TRIPLE),
    .PAYOUT_PAIR(P_PAIR)
  ) u_dut (
    .clk(clk), .rst(rst_n), .tick(tick), .start_btn(start_btn), .stop_btn(stop_btn),
    .reel0(reel0), .reel1(reel1), .reel2(reel2), .reel_step(reel_step),
    .credits(credits), .win_triple(win_triple), .win_pair(win_pair),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the game: balance and last-result flags.
  int         m_cred;
  bit         m_tri, m_pair;
  bit         tk [NCYC];
  logic [3:0] rv [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle index of the n-th tick at or after cycle 'from'.
  function automatic int nth_tick(input int from, input int n);
    int seen = 0;
    for (int k = from; k < NCYC; k++) begin
      if (tk[k]) begin
        seen++;
        if (seen == n) return k;
      end
    end
    return NCYC - 1;
  endfunction

  task automatic cyc(input bit t, input bit s, input bit p);
    @(negedge clk);
    tick = t; start_btn = s; stop_btn = p;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_credits", credits, START_C);
    chk("rst_step", reel_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {win_triple, win_pair}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cred = START_C; m_tri = 1'b0; m_pair = 1'b0;
  endtask

  // One full game round. Cycle 0: stop press in IDLE (ignored); cycle 2: start
  // press; SPIN from cycle 3. mode 0: free-running reels, 1: triple 7,7,7,
  // 2: pair 3,5,3, 3: no match 1,2,3, 4: small random values (frequent matches).
  // hold=1 keeps both buttons high to the end to exercise no-retrigger.
  task automatic do_spin(input int mode, input bit hold);
    int sc, t_to, e1, e2, e3, e4, e5, last, est, pre_cred, post_cred, pay;
    bit pre_tri, pre_pair, post_tri, post_pair, ea, eb;
    logic [2:0] mask;
    for (int k = 0; k < NCYC; k++) tk[k] = (k % 4 == 3) || ($urandom_range(0, 2) == 0);
    sc   = $urandom_range(3, 140);
    t_to = nth_tick(3, MAXSPIN);
    e1   = ((sc < t_to) ? sc : t_to) + 1;
    e2   = nth_tick(e1, STAG) + 1;
    e3   = nth_tick(e2, STAG) + 1;
    e4   = e3 + 1;
    e5   = nth_tick(e4, HOLD) + 1;
    last = e5 + 3;
    pre_cred = m_cred; pre_tri = m_tri; pre_pair = m_pair;
    post_cred = pre_cred - 1; post_tri = 1'b0; post_pair = 1'b0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      tick      = tk[k];
      start_btn = hold ? (k >= 2) : ((k >= 2 && k <= 4) || (k == e4 + 1));
      stop_btn  = (k == 0) || (hold ? (k >= sc) : (k >= sc && k < sc + 3));
      if (k == e3) begin
        case (mode)
          1: begin rv[0] = 4'd7; rv[1] = 4'd7; rv[2] = 4'd7; end
          2: begin rv[0] = 4'd3; rv[1] = 4'd5; rv[2] = 4'd3; end
          3: begin rv[0] = 4'd1; rv[1] = 4'd2; rv[2] = 4'd3; end
          4: for (int i = 0; i < 3; i++) rv[i] = 4'($urandom_range(0, 2));
          default: ;
        endcase
      end
      reel0 = rv[0]; reel1 = rv[1]; reel2 = rv[2];
      #1;
      if (k == e3) begin
        ea = (rv[0] == rv[1]) && (rv[1] == rv[2]);
        eb = !ea && ((rv[0] == rv[1]) || (rv[1] == rv[2]) || (rv[0] == rv[2]));
        pay = ea ? P_TRIPLE : (eb ? P_PAIR : 0);
        post_cred = pre_cred - 1 + pay;
        if (post_cred > SAT) post_cred = SAT;
        post_tri = ea; post_pair = eb;
      end
      est  = (k < 3) ? 0 : (k < e1) ? 1 : (k < e2) ? 2 : (k < e3) ? 3 :
             (k == e3) ? 4 : (k < e5) ? 5 : 0;
      mask = (est == 1) ? 3'b111 : (est == 2) ? 3'b110 : (est == 3) ? 3'b100 : 3'b000;
      chk("state", state, est);
      chk("reel_step", reel_step, mask & {3{tick}});
      chk("busy", busy, est != 0);
      chk("credits", credits, (k < 3) ? pre_cred : (k < e4) ? pre_cred - 1 : post_cred);
      chk("win_triple", win_triple, (k < 3) ? pre_tri : (k < e4) ? 1'b0 : post_tri);
      chk("win_pair", win_pair, (k < 3) ? pre_pair : (k < e4) ? 1'b0 : post_pair);
      // Reel environment: a reel advances when its step enable is high.
      for (int i = 0; i < 3; i++) if (reel_step[i]) rv[i] = rv[i] + 4'd1;
    end
    @(negedge clk);
    start_btn = 1'b0; stop_btn = 1'b0; tick = 1'b0;
    m_cred = post_cred; m_tri = post_tri; m_pair = post_pair;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
    for (int i = 0; i < 3; i++) rv[i] = 4'($urandom_range(0, 15));
    reel0 = rv[0]; reel1 = rv[1]; reel2 = rv[2];
    apply_reset();

    // Scoring cases, then random rounds including held buttons.
    do_spin(1, 1'b0);
    do_spin(2, 1'b0);
    do_spin(3, 1'b0);
    do_spin(0, 1'b0);
    do_spin(4, 1'b0);
    do_spin(4, 1'b1);
    do_spin(0, 1'b1);
    do_spin(4, 1'b0);

    // Reset arriving mid-SPIN takes effect within the cycle and holds.
    cyc(1'b0, 1'b1, 1'b0);
    chk("mid_spin_state", state, 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_credits", credits, START_C);
    chk("async_rst_step", reel_step, 0);
    chk("async_rst_flags", {win_triple, win_pair}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("rst_hold_state", state, 0);
      chk("rst_hold_step", reel_step, 0);
      chk("rst_hold_credits", credits, START_C);
    end
    @(negedge clk);
    rst_n = 1'b1; start_btn = 1'b0; tick = 1'b0;
    m_cred = START_C; m_tri = 1'b0; m_pair = 1'b0;

    // Climb to saturation with triples.
    while (m_cred < SAT) do_spin(1, 1'b0);
    do_spin(1, 1'b0);

    // Drain to zero; a start with no credits is ignored.
    apply_reset();
    while (m_cred > 0) do_spin(3, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("zero_cred_state", state, 0);
    chk("zero_cred_credits", credits, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("zero_cred_state2", state, 0);
    chk("zero_cred_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
